cla_bist: RTL and testbench
===========================

CLA_BIST -- requirements
Module: cla_bist

Interface
REQ-001 Parameter SETTLE, default 1, range 1-15: clock cycles each vector is held on the adder inputs before its result is sampled.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 dut_a  output  4  operand A driven to the 4-bit adder under test.
REQ-006 dut_b  output  4  operand B driven to the adder under test.
REQ-007 dut_cin  output  1  carry-in driven to the adder under test.
REQ-008 dut_sum  input  4  sum returned by the adder under test.
REQ-009 dut_cout  input  1  carry-out returned by the adder under test.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  one-cycle pulse at end of run.
REQ-012 pass  output  1  result of the last completed run; 1 = no mismatches.
REQ-013 err_count  output  10  number of mismatching vectors in the current or last run.
REQ-014 first_fail_vec  output  9  index of the first mismatching vector.
REQ-015 first_fail_valid  output  1  first_fail_vec holds a captured index.

Function
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 The 9-bit vector index v SHALL map as dut_a=v[8:5], dut_b=v[4:1], dut_cin=v[0], with v stepping 0 to 511 in ascending order.
REQ-018 All dut_* outputs SHALL be registered.
REQ-019 In IDLE with start=1, the next edge SHALL do all of the following: load v=0, clear err_count, clear first_fail_vec, clear first_fail_valid, set busy=1 and enter RUN.
REQ-020 pass SHALL be left unchanged by start acceptance.
REQ-021 In RUN, each vector SHALL be held for exactly SETTLE cycles.
REQ-022 On the edge ending the last cycle of each vector, the block SHALL compare {dut_cout,dut_sum} against the 5-bit value dut_a+dut_b+dut_cin.
REQ-023 On a mismatch, err_count SHALL increment by 1.
REQ-024 On the first mismatch of a run, first_fail_vec SHALL capture v and first_fail_valid SHALL set to 1.
REQ-025 Later mismatches SHALL NOT alter first_fail_vec.
REQ-026 At the compare edge, if v<511 the block SHALL load v+1 and remain in RUN; if v=511 it SHALL enter DONE.
REQ-027 A full run SHALL last exactly 512*SETTLE cycles from start acceptance to entry into DONE.
REQ-028 In DONE, for one cycle, the block SHALL set done=1, busy=0 and pass=(err_count==0), then return to IDLE.
REQ-029 err_count, first_fail_vec and first_fail_valid SHALL hold their values in IDLE until the next start is accepted.
REQ-030 start SHALL be ignored in RUN and DONE, and SHALL NOT queue a run.
REQ-031 err_count SHALL have a maximum value of 512; no saturation logic SHALL be required.
REQ-032 The settle counter SHALL be 4 bits wide and SHALL reload at every vector change.

Reset
REQ-033 While rst_n=0, and immediately on its assertion, the FSM SHALL be in IDLE.
REQ-034 While rst_n=0, dut_a, dut_b, dut_cin, busy, done, pass, err_count, first_fail_vec and first_fail_valid SHALL all be 0.
REQ-035 Asserting reset in the middle of a run SHALL abort the run with no done pulse.
REQ-036 The first start after reset deasserts SHALL begin a complete new run.

Verification
REQ-037 Correct adder, SETTLE=1, start pulsed once: done after 512 cycles, pass=1, err_count=0, first_fail_valid=0.
REQ-038 Adder with dut_cout stuck at 0: err_count=256, first_fail_vec=31 (a=0, b=15, cin=1), pass=0.
REQ-039 Adder with dut_sum[0] stuck at 1: err_count=256, first_fail_vec=0, pass=0.
REQ-040 start held high for the entire run: exactly one done pulse per accepted run, no start accepted during RUN, next run begins on the edge after the return to IDLE.
REQ-041 rst_n pulsed low at cycle 100 of a run: all outputs 0 at once, no done pulse; a following start completes a normal passing run.
REQ-042 SETTLE=3, correct adder: each vector held 3 cycles, done after 1536 cycles, pass=1.

Source files
------------

// File: rtl/cla_bist.sv
// Built-in self-test sequencer for a 4-bit adder.
// Sweeps all 512 {a,b,cin} vectors and counts sum/carry mismatches.
module cla_bist #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  output logic       dut_cin,
  input  logic [3:0] dut_sum,
  input  logic       dut_cout,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_count,
  output logic [8:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

  state_t     state;
  state_t     state_n;
  logic [8:0] v;
  logic [3:0] cnt;
  logic [4:0] exp_sum;
  logic       cmp;
  logic       last;
  logic       miss;
  logic       accept;

  assign {dut_a, dut_b, dut_cin} = v;

  assign exp_sum = {1'b0, dut_a}
                 + {1'b0, dut_b}
                 + {4'b0, dut_cin};
  assign miss   = {dut_cout, dut_sum} != exp_sum;
  assign cmp    = (state == RUN) && (cnt == 4'd0);
  assign last   = (v == 9'd511);
  assign accept = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state decode
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start)       state_n = RUN;
      RUN:     if (cmp && last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Status outputs follow the registered state
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Vector sweep, settle timing and mismatch bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v                <= '0;
      cnt              <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else if (accept) begin
      v                <= '0;
      cnt              <= RELOAD;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else if (state == RUN) begin
      if (!cmp) begin
        cnt <= cnt - 4'd1;
      end else begin
        cnt <= RELOAD;
        if (!last) v <= v + 9'd1;
        if (miss) err_count <= err_count + 10'd1;
        if (miss && !first_fail_valid) begin
          first_fail_vec   <= v;
          first_fail_valid <= 1'b1;
        end
        if (last) pass <= (err_count == 10'd0) && !miss;
      end
    end
  end

endmodule

// File: tb/tb_cla_bist.sv
// Bench for cla_bist: two instances (SETTLE=1, SETTLE=3) driving
// a behavioural adder with selectable stuck-at and random faults.
module tb_cla_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start [2];
  logic [3:0] a     [2];
  logic [3:0] b     [2];
  logic       cin   [2];
  logic [3:0] sum   [2];
  logic       cout  [2];
  logic       busy  [2];
  logic       done  [2];
  logic       pass  [2];
  logic [9:0] err   [2];
  logic [8:0] ffv   [2];
  logic       ffok  [2];

  int         mode  [2];
  logic [511:0] mask;

  int checks = 0;
  int failures = 0;

  // Adder under test: 0 good, 1 cout stuck 0, 2 sum[0] stuck 1,
  // 3 LSB flipped on vectors selected by mask
  function automatic logic [4:0] adder(input int m,
                                       input logic [8:0] vv,
                                       input logic [511:0] mk);
    logic [4:0] r;
    r = 5'(vv[8:5]) + 5'(vv[4:1]) + 5'(vv[0]);
    case (m)
      1: r[4] = 1'b0;
      2: r[0] = 1'b1;
      3: if (mk[vv]) r = r ^ 5'h01;
      default: ;
    endcase
    return r;
  endfunction

  assign {cout[0], sum[0]} = adder(mode[0], {a[0], b[0], cin[0]}, mask);
  assign {cout[1], sum[1]} = adder(mode[1], {a[1], b[1], cin[1]}, mask);

  cla_bist #(.SETTLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .dut_a(a[0]), .dut_b(b[0]), .dut_cin(cin[0]),
    .dut_sum(sum[0]), .dut_cout(cout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err[0]), .first_fail_vec(ffv[0]),
    .first_fail_valid(ffok[0])
  );

  cla_bist #(.SETTLE(3)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .dut_a(a[1]), .dut_b(b[1]), .dut_cin(cin[1]),
    .dut_sum(sum[1]), .dut_cout(cout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err[1]), .first_fail_vec(ffv[1]),
    .first_fail_valid(ffok[1])
  );

  // Reference: sweep every vector, compare faulty adder with true sum
  task automatic ref_run(input int m, output int errs, output int first);
    logic [4:0] r;
    int t;
    errs = 0;
    first = -1;
    for (int vv = 0; vv < 512; vv++) begin
      r = adder(m, 9'(vv), mask);
      t = (vv >> 5) + ((vv >> 1) & 15) + (vv & 1);
      if (int'(r) != t) begin
        errs++;
        if (first < 0) first = vv;
      end
    end
  endtask

  // Start a run and follow it to done, recording vector hold behaviour
  task automatic do_run(input int i, input bit hold,
                        output int cyc, output int bad,
                        output int nvec, output logic p0);
    int settle;
    int rl;
    logic [8:0] pv;
    logic [8:0] cv;
    settle = (i == 0) ? 1 : 3;
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
    p0 = pass[i];
    cyc = 0;
    bad = 0;
    nvec = 1;
    pv = {a[i], b[i], cin[i]};
    rl = 1;
    if (pv != 9'd0 || !busy[i]) bad++;
    while (!done[i] && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (!done[i]) begin
        cv = {a[i], b[i], cin[i]};
        if (!busy[i]) bad++;
        if (cv != pv) begin
          if (rl != settle || cv != pv + 9'd1) bad++;
          nvec++;
          pv = cv;
          rl = 1;
        end else begin
          rl++;
        end
      end
    end
    if (rl != settle || pv != 9'd511) bad++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({a[i], b[i], cin[i], busy[i], done[i], pass[i],
           err[i], ffv[i], ffok[i]} !== 32'd0) begin
        failures++;
        $display("FAIL reset_state inst%0d: a=%h b=%h cin=%b busy=%b done=%b pass=%b err=%0d ffv=%0d ffok=%b, required all 0",
                 i, a[i], b[i], cin[i], busy[i], done[i], pass[i],
                 err[i], ffv[i], ffok[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_run(input int i, input int m, input string nm);
    int cyc, bad, nv, e, f;
    logic p0;
    logic prev_pass;
    prev_pass = pass[i];
    mode[i] = m;
    ref_run(m, e, f);
    do_run(i, 1'b0, cyc, bad, nv, p0);
    checks++;
    if (cyc !== ((i == 0) ? 512 : 1536)) begin
      failures++;
      $display("FAIL %s_cycles: got %0d required %0d", nm, cyc,
               (i == 0) ? 512 : 1536);
    end
    checks++;
    if (bad !== 0 || nv !== 512) begin
      failures++;
      $display("FAIL %s_sweep: hold/order errors %0d vectors %0d, required 0 and 512",
               nm, bad, nv);
    end
    checks++;
    if (p0 !== prev_pass) begin
      failures++;
      $display("FAIL %s_pass_kept: pass after start %b required %b",
               nm, p0, prev_pass);
    end
    checks++;
    if (err[i] !== 10'(e)) begin
      failures++;
      $display("FAIL %s_err_count: got %0d required %0d", nm, err[i], e);
    end
    checks++;
    if (ffok[i] !== (f >= 0) || (f >= 0 && ffv[i] !== 9'(f))) begin
      failures++;
      $display("FAIL %s_first_fail: valid=%b vec=%0d required valid=%b vec=%0d",
               nm, ffok[i], ffv[i], f >= 0, f);
    end
    checks++;
    if (pass[i] !== (e == 0) || busy[i] !== 1'b0) begin
      failures++;
      $display("FAIL %s_pass: pass=%b busy=%b required pass=%b busy=0",
               nm, pass[i], busy[i], e == 0);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (err[i] !== 10'(e) || done[i] !== 1'b0 || busy[i] !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_hold: err=%0d done=%b busy=%b required err=%0d done=0 busy=0",
               nm, err[i], done[i], busy[i], e);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bad, nv;
    logic p0;
    mode[0] = 0;
    do_run(0, 1'b1, cyc, bad, nv, p0);
    checks++;
    if (cyc !== 512 || bad !== 0) begin
      failures++;
      $display("FAIL b2b_first_run: cycles %0d errors %0d required 512 and 0",
               cyc, bad);
    end
    @(negedge clk);
    checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle_gap: done=%b busy=%b required 0 0",
               done[0], busy[0]);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b1 || {a[0], b[0], cin[0]} !== 9'd0) begin
      failures++;
      $display("FAIL b2b_restart: busy=%b v=%0d required busy=1 v=0",
               busy[0], {a[0], b[0], cin[0]});
    end
    cyc = 0;
    while (!done[0] && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    start[0] = 1'b0;
    checks++;
    if (cyc !== 512) begin
      failures++;
      $display("FAIL b2b_second_run: got %0d cycles required 512", cyc);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy[0] || done[0]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_no_queue: %0d busy/done cycles after release, required 0",
               bad);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    int cyc, bad, nv;
    logic p0;
    mode[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a[0], b[0], cin[0], busy[0], done[0], pass[0],
         err[0], ffv[0], ffok[0]} !== 32'd0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: busy=%b v=%0d pass=%b err=%0d, required all 0",
               busy[0], {a[0], b[0], cin[0]}, pass[0], err[0]);
    end
    repeat (3) begin
      @(negedge clk);
      if (done[0]) seen++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL midrun_no_done: %0d done/busy samples, required 0", seen);
    end
    do_run(0, 1'b0, cyc, bad, nv, p0);
    checks++;
    if (cyc !== 512 || bad !== 0 || pass[0] !== 1'b1 || err[0] !== 10'd0) begin
      failures++;
      $display("FAIL midrun_rerun: cycles %0d errors %0d pass=%b err=%0d required 512 0 1 0",
               cyc, bad, pass[0], err[0]);
    end
  endtask

  initial begin
    mode[0] = 0;
    mode[1] = 0;
    mask = '0;
    for (int k = 0; k < 512; k++) mask[k] = ($urandom % 5) == 0;
    mask[$urandom % 512] = 1'b1;
    test_reset();
    test_run(0, 0, "good_s1");
    test_run(0, 1, "cout_stuck0");
    test_run(0, 0, "good_after_fail");
    test_run(0, 2, "sum0_stuck1");
    test_run(0, 3, "random_faults");
    test_back_to_back();
    test_reset_mid();
    test_run(1, 0, "good_s3");
    test_run(1, 3, "random_s3");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
